seq_divider: RTL

- Sequential restoring unsigned divider. It is the inverse of the 8-bit multiplier datapath: it takes a 2N-bit dividend (product width) and an N-bit divisor, and returns a 2N-bit quotient and an N-bit remainder.
- Resolves one quotient bit per cycle using an (N+1)-bit trial subtract.
- Uses valid/ready handshakes on both sides. It sits between the multiplier result path and downstream consumers.

---
 rtl/seq_divider.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: 2N-bit dividend / N-bit divisor, one quotient bit per cycle.
// Optional DIV_EARLY_DONE_EN: finish in one cycle when dividend < divisor.
module seq_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready and out_valid are pure decodes of the state register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            CW   = $clog2(2 * N);
    localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [N-1:0]  dvs;

    logic          zero_div;
    logic          early;
    logic [N:0]    trial;
    logic [N+1:0]  diff;
    logic          borrow;
    logic [N:0]    r_step;
    logic          unused_r_msb;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign zero_div = (divisor == '0);
`ifdef DIV_EARLY_DONE_EN
    assign early = (dividend < {{N{1'b0}}, divisor});
`else
    assign early = 1'b0;
`endif

    // The quotient register doubles as the dividend shift register: dividend bits
    // leave from the MSB while quotient bits enter at the LSB.
    assign trial  = {remainder, quotient[2*N-1]};
    assign diff   = {1'b0, trial} - {2'b00, dvs};
    assign borrow = diff[N+1];
    // Both candidates are below the divisor, so the top bit is always zero.
    assign r_step       = borrow ? trial : diff[N:0];
    assign unused_r_msb = r_step[N];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (zero_div || early) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            dvs         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs <= divisor;
                        cnt <= '0;
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b1;
                        end else if (early) begin
                            quotient    <= '0;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b0;
                        end else begin
                            quotient    <= dividend;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    quotient    <= {quotient[2*N-2:0], ~borrow};
                    remainder   <= r_step[N-1:0];
                    cnt         <= cnt + 1'b1;
                    div_by_zero <= 1'b0;
                end
                default: begin
                    // DONE holds results stable until the consumer takes them.
                end
            endcase
        end
    end

endmodule
